// File: rtl/alu_req_scheduler_pkg.sv
// rtl/alu_req_scheduler_pkg.sv - shared constants and types for the ALU request scheduler
package alu_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int N_REQ_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT   = 7;
    localparam int ID_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/alu_req_scheduler_if.sv
// rtl/alu_req_scheduler_if.sv - requester channels and ALU-side signals of the scheduler
interface alu_req_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [2*N_REQ-1:0] req_op;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_ready;
    logic [15:0]        rsp_result;
    logic               rsp_err;
    logic               alu_start;
    logic [1:0]         alu_op_code;
    logic [7:0]         alu_operand_a;
    logic [7:0]         alu_operand_b;
    logic [15:0]        alu_result;
    logic               alu_done;

    // requesters plus the ALU, i.e. everything around the scheduler
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_done,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
        input  alu_start, alu_op_code, alu_operand_a, alu_operand_b
    );

    // the scheduler itself
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_done,
        output req_ready, rsp_valid, rsp_result, rsp_err,
        output alu_start, alu_op_code, alu_operand_a, alu_operand_b
    );
endinterface

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// rtl/alu_req_scheduler_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);
    logic            hi_hit;
    logic            lo_hit;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // lowest request at/above ptr wins; otherwise wrap to the lowest request overall
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_hit = 1'b1;
                lo_idx = ID_W'(j);
                if (j >= int'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = ID_W'(j);
                end
            end
        end
    end

    assign any_req   = lo_hit;
    assign grant_idx = hi_hit ? hi_idx : lo_idx;

    // expand the winning index to a one-hot grant
    always_comb begin
        grant = '0;
        for (int j = 0; j < N_REQ; j++) begin
            grant[j] = any_req && (grant_idx == ID_W'(j));
        end
    end
endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one ALU between N_REQ requesters with RR arbitration and watchdog
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    alu_req_scheduler_if.slave bus,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id
);
    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant_oh;
    logic [1:0]       op_sel;
    logic [7:0]       a_sel;
    logic [7:0]       b_sel;
    logic [1:0]       op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [15:0]      result_q;
    logic             err_q;
    logic             done_q;
    logic [CNT_W-1:0] wdog;
    logic             complete;
    logic             timeout_hit;
    logic             rsp_ack;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // operand mux for the current arbitration winner
    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                op_sel = bus.req_op[2*i +: 2];
                a_sel  = bus.req_a[8*i +: 8];
                b_sel  = bus.req_b[8*i +: 8];
            end
        end
    end

    // only a fresh rising edge of done counts, so a done level left over from the previous op is ignored
    assign complete    = bus.alu_done & ~done_q;
    assign timeout_hit = (wdog == CNT_W'(TIMEOUT - 1));
    assign rsp_ack     = |(bus.rsp_ready & grant_oh);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; completion takes priority over a coinciding timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (complete || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // outputs decoded from state; operands come from the holding regs so they stay put for the whole op
    always_comb begin
        busy              = (state != ST_IDLE);
        bus.req_ready     = (state == ST_IDLE) ? arb_grant : '0;
        bus.alu_start     = (state == ST_ISSUE);
        bus.rsp_valid     = (state == ST_RESP) ? grant_oh : '0;
        bus.rsp_result    = (state == ST_RESP) ? result_q : '0;
        bus.rsp_err       = (state == ST_RESP) ? err_q : 1'b0;
        bus.alu_op_code   = busy ? op_q : '0;
        bus.alu_operand_a = busy ? a_q : '0;
        bus.alu_operand_b = busy ? b_q : '0;
    end

    // holding registers, rr pointer, watchdog and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            grant_oh <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            wdog     <= '0;
        end else begin
            done_q <= bus.alu_done;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        op_q     <= op_sel;
                        a_q      <= a_sel;
                        b_q      <= b_sel;
                        grant_id <= arb_idx;
                        grant_oh <= arb_grant;
                        rr_ptr   <= (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                    end
                end
                ST_ISSUE: begin
                    wdog <= '0;
                end
                ST_WAIT: begin
                    wdog <= wdog + CNT_W'(1);
                    if (complete) begin
                        result_q <= bus.alu_result;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - randomized scoreboard bench for alu_req_scheduler
module tb_alu_req_scheduler;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [2:0] grant_id;

    alu_req_scheduler_if #(.N_REQ(N)) bus ();

    alu_req_scheduler #(.N_REQ(N), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   ptr_m = 0;
    int   alu_mode = 0;
    int   reload_cnt[N];
    int   stall_left = 0;
    bit   stall_arm = 0;
    bit   bp_random = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return 16'(a) + 16'(b);
            2'b01:   return 16'(a) - 16'(b);
            2'b10:   return 16'(a) * 16'(b);
            default: return (b == 8'd0) ? 16'hFFFF : {a % b, a / b};
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic post(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[2*i +: 2] = op;
        bus.req_a[8*i +: 8]  = a;
        bus.req_b[8*i +: 8]  = b;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic post_rand(input int i);
        post(i, 2'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
        chk({tag, "_alu_ops"}, {14'd0, bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_valid == '0 && exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        chk({tag, "_drain_timeout"}, 32'(ok), 32'd1);
        @(posedge clk);
        #2;
    endtask

    // acceptance monitor: predicts the round-robin winner and queues the expected response
    initial begin : accept_p
        int   c;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && !busy && bus.req_valid != '0) begin
                c = rr_pick(bus.req_valid, ptr_m);
                chk("grant", 32'(bus.req_ready), 32'd1 << c);
                e.id  = c;
                e.op  = bus.req_op[2*c +: 2];
                e.a   = bus.req_a[8*c +: 8];
                e.b   = bus.req_b[8*c +: 8];
                e.err = (alu_mode == 1);
                exp_q.push_back(e);
                ptr_m = (c + 1) % N;
                @(posedge clk);
                #1;
                if (reload_cnt[c] > 0) begin
                    reload_cnt[c]--;
                    post_rand(c);
                end else begin
                    bus.req_valid[c] = 1'b0;
                end
            end
        end
    end

    // response monitor: pops the scoreboard on each new response, checks hold behaviour while stalled
    initial begin : rsp_p
        exp_t        e;
        bit          in_resp;
        int          start_cycles;
        int          wait_cnt;
        int          cur_id;
        logic [15:0] hold_res;
        logic        hold_err;
        logic [N-1:0] hold_vld;
        in_resp = 0; start_cycles = 0; wait_cnt = 0; cur_id = 0;
        hold_res = '0; hold_err = 1'b0; hold_vld = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_resp = 0; start_cycles = 0; wait_cnt = 0;
            end else begin
                if (bus.alu_start) begin
                    start_cycles++;
                    wait_cnt = 0;
                end else if (busy && bus.rsp_valid == '0) begin
                    wait_cnt++;
                end
                if (bus.rsp_valid != '0) begin
                    if (!in_resp) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            cur_id = e.id;
                            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.id);
                            chk("grant_id", 32'(grant_id), 32'(e.id));
                            chk("rsp_result", 32'(bus.rsp_result), e.err ? 32'd0 : 32'(alu_ref(e.op, e.a, e.b)));
                            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                            chk("alu_ops_held", {14'd0, bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b},
                                {14'd0, e.op, e.a, e.b});
                            chk("start_pulse_len", 32'(start_cycles), 32'd1);
                            if (e.err) chk("timeout_wait_cycles", 32'(wait_cnt), 32'(TIMEOUT));
                        end
                        hold_res = bus.rsp_result;
                        hold_err = bus.rsp_err;
                        hold_vld = bus.rsp_valid;
                        in_resp  = 1;
                    end else begin
                        chk("hold_result", 32'(bus.rsp_result), 32'(hold_res));
                        chk("hold_err", 32'(bus.rsp_err), 32'(hold_err));
                        chk("hold_valid", 32'(bus.rsp_valid), 32'(hold_vld));
                        chk("no_grant_in_resp", 32'(bus.req_ready), 32'd0);
                    end
                    if (bus.rsp_ready[cur_id]) begin
                        in_resp = 0;
                        start_cycles = 0;
                    end
                end
            end
        end
    end

    // ALU model: mode 0 pulses done after a random delay, 1 never finishes, 2 leaves done high then re-pulses late
    initial begin : alu_p
        logic [15:0] mres;
        int          lat;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.alu_start) begin
                mres = alu_ref(bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b);
                case (alu_mode)
                    0: begin
                        bus.alu_done = 1'b0;
                        lat = $urandom_range(1, 6);
                        repeat (lat) @(posedge clk);
                        #1;
                        bus.alu_result = mres;
                        bus.alu_done   = 1'b1;
                        @(posedge clk);
                        #1;
                        bus.alu_done = 1'b0;
                    end
                    1: begin
                        bus.alu_done   = 1'b0;
                        bus.alu_result = 16'hDEAD;
                    end
                    default: begin
                        bus.alu_result = 16'hBAD0;
                        bus.alu_done   = 1'b1;
                        repeat (4) @(posedge clk);
                        #1;
                        bus.alu_done = 1'b0;
                        @(posedge clk);
                        #1;
                        bus.alu_result = mres;
                        bus.alu_done   = 1'b1;
                    end
                endcase
            end
        end
    end

    // response-ready driver: always-ready, random backpressure, or a 10-cycle stall on the next response
    initial begin : rdy_p
        bus.rsp_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.rsp_ready = '0;
                stall_left--;
            end else if (stall_arm && bus.rsp_valid != '0) begin
                stall_arm     = 0;
                stall_left    = 9;
                bus.rsp_ready = '0;
            end else begin
                bus.rsp_ready = bp_random ? N'($urandom) : '1;
            end
        end
    end

    initial begin : main_p
        int  issued;
        int  i;
        bit  seen;
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int k = 0; k < N; k++) reload_cnt[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;

        alu_mode = 0;
        post(0, 2'b00, 8'd20, 8'd15);
        wait_idle("add");

        post(1, 2'b10, 8'd7, 8'd6);
        post(2, 2'b11, 8'd200, 8'd13);
        wait_idle("mul_div");

        for (int k = 0; k < N; k++) begin
            reload_cnt[k] = 1;
            post_rand(k);
        end
        wait_idle("all_valid");

        alu_mode = 2;
        post_rand(1);
        wait_idle("held_done_a");
        post_rand(3);
        wait_idle("held_done_b");

        alu_mode = 1;
        post_rand(2);
        wait_idle("timeout");
        alu_mode = 0;
        post_rand(2);
        wait_idle("after_timeout");

        stall_arm = 1;
        post_rand(0);
        wait_idle("stall");

        bp_random = 1;
        issued = 0;
        for (int k = 0; k < 2000 && issued < 30; k++) begin
            @(posedge clk);
            #2;
            i = $urandom_range(0, N - 1);
            if (!bus.req_valid[i]) begin
                post_rand(i);
                issued++;
            end
        end
        wait_idle("random");
        bp_random = 0;

        alu_mode = 1;
        post_rand(1);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.alu_start) seen = 1;
        end
        chk("midrst_start_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midrst");
        ptr_m = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        alu_mode = 0;
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) post_rand(k);
        wait_idle("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
